fifo_wr_arb: RTL and testbench

Write-side arbiter for the asynchronous FIFO, in the `wclk` domain. It shares the FIFO's single write port among `NREQ` packet-oriented requesters. A requester owns the port for one packet, or for at most `MAXBURST` beats, and grants rotate round-robin between requesters. Write beats are gated by the FIFO's registered full flag, and the block counts cycles lost to backpressure.

---
 rtl/fifo_wr_arb.sv | 113 +++++++++++
 tb/tb_fifo_wr_arb.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
// Write-side arbiter for the async FIFO: round-robin packet grants on a single
// write port, burst-capped, gated by the registered full flag, with a stall counter.
module fifo_wr_arb #(
  parameter int NREQ     = 4,
  parameter int DSIZE    = 8,
  parameter int MAXBURST = 4,
  parameter int IDW      = $clog2(NREQ)
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy,
  output logic [15:0]           stall_cnt
);

  localparam int BCW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_last_grant;
  logic [IDW-1:0] r_grant;
  logic [BCW-1:0] r_beat_cnt;
  logic [15:0]    r_stall;

  logic [IDW-1:0] w_pick;
  logic [IDW-1:0] w_idx;
  logic [31:0]    w_sum;
  logic           w_any;
  logic           w_xfer;
  logic           w_gvalid;
  logic           w_beat;
  logic           w_end;
  logic           w_stall;

  // Round-robin search starting one past the previous owner, wrapping modulo NREQ.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_sum  = '0;
    w_idx  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_sum = 32'(r_last_grant) + k;
      w_idx = IDW'(w_sum % 32'(NREQ));
      if (!w_any && req_valid[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  assign w_xfer   = (r_state == S_XFER);
  assign w_gvalid = req_valid[r_grant];
  assign w_beat   = w_xfer & w_gvalid & ~wfull;
  assign w_end    = w_beat & (req_last[r_grant] | (r_beat_cnt == BCW'(MAXBURST - 1)));
  assign w_stall  = w_xfer & w_gvalid & wfull;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_XFER;
      S_XFER:  if (w_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (w_xfer) req_ready[r_grant] = ~wfull;
    winc  = w_beat;
    busy  = w_xfer;
    wdata = req_data[r_grant*DSIZE +: DSIZE];
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_last_grant <= IDW'(NREQ - 1);
      r_grant      <= '0;
      r_beat_cnt   <= '0;
      r_stall      <= '0;
    end else begin
      if (!w_xfer && w_any) begin
        r_grant    <= w_pick;
        r_beat_cnt <= '0;
      end
      if (w_beat) begin
        if (w_end) r_last_grant <= r_grant;
        else       r_beat_cnt   <= r_beat_cnt + 1'b1;
      end
      if (w_stall && (r_stall != '1)) r_stall <= r_stall + 16'd1;
    end
  end

  assign grant_id  = r_grant;
  assign stall_cnt = r_stall;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: reset-priority vector table, directed packet/burst/backpressure/
// saturation/reset sequences, and randomized traffic against a per-cycle reference model.
module tb_fifo_wr_arb;

  localparam int NREQ     = 4;
  localparam int DSIZE    = 8;
  localparam int MAXBURST = 4;
  localparam int IDW      = 2;

  logic                  wclk = 1'b0;
  logic                  wrst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [IDW-1:0]        grant_id;
  logic                  busy;
  logic [15:0]           stall_cnt;

  always #5 wclk = ~wclk;

  fifo_wr_arb #(
    .NREQ(NREQ), .DSIZE(DSIZE), .MAXBURST(MAXBURST), .IDW(IDW)
  ) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .wfull(wfull), .winc(winc),
    .wdata(wdata), .grant_id(grant_id), .busy(busy), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [NREQ-1:0] last;
    logic            wfull;
    logic            busy;
    logic            winc;
    logic [IDW-1:0]  grant;
    logic [NREQ-1:0] ready;
  } vec_t;

  vec_t tbl[10];

  int checks = 0;
  int errors = 0;

  // Reference model: owner (-1 = arbitrating), previous owner, beats delivered this grant.
  int m_owner, m_last, m_grant, m_beats, m_stall;
  logic            e_winc, e_busy;
  logic [NREQ-1:0] e_ready, acc;
  int e_grant, e_stall;

  // Requester traffic generators: beats left in current packet, next data sequence number.
  int rem[NREQ];
  int dcnt[NREQ];
  logic [NREQ-1:0] gap;
  bit gen_on, rnd_on;

  int          log_g[$];
  logic [7:0]  log_d[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_chk(input string name, input int n, input int lim);
    checks++;
    if (n >= lim) begin
      errors++;
      $display("FAIL %s: timeout after %0d cycles, limit %0d", name, n, lim);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = NREQ - 1; m_grant = 0; m_beats = 0; m_stall = 0;
  endtask

  task automatic predict();
    e_busy  = (m_owner >= 0);
    e_grant = m_grant;
    e_stall = m_stall;
    e_ready = '0;
    e_winc  = 1'b0;
    if (m_owner >= 0) begin
      e_ready[m_owner] = !wfull;
      e_winc = req_valid[m_owner] && !wfull;
    end
    acc = req_valid & e_ready;
  endtask

  task automatic model_step();
    bit found;
    int idx;
    if (m_owner < 0) begin
      found = 0;
      for (int k = 1; k <= NREQ; k++) begin
        idx = (m_last + k) % NREQ;
        if (!found && req_valid[idx]) begin
          found = 1; m_owner = idx; m_grant = idx; m_beats = 0;
        end
      end
    end else begin
      if (req_valid[m_owner] && wfull && m_stall < 65535) m_stall++;
      if (e_winc) begin
        m_beats++;
        if (req_last[m_owner] || m_beats == MAXBURST) begin
          m_last = m_owner; m_owner = -1;
        end
      end
    end
  endtask

  task automatic compare();
    chk("busy", busy, e_busy);
    chk("winc", winc, e_winc);
    chk("req_ready", req_ready, e_ready);
    chk("grant_id", grant_id, e_grant);
    chk("stall_cnt", stall_cnt, e_stall);
    if (e_winc) begin
      chk("wdata", wdata, req_data[m_owner*DSIZE +: DSIZE]);
      log_g.push_back(m_owner);
      log_d.push_back(wdata);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (rem[i] > 0) && !gap[i];
      req_last[i]  = (rem[i] == 1);
      req_data[i*DSIZE +: DSIZE] = DSIZE'((i << 6) | (dcnt[i] & 63));
    end
  endtask

  task automatic advance();
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin rem[i]--; dcnt[i]++; end
      if (rnd_on && rem[i] == 0 && $urandom_range(3) == 0) rem[i] = $urandom_range(7, 1);
    end
  endtask

  task automatic pre();
    predict();
    #3;
    compare();
  endtask

  task automatic post();
    @(posedge wclk);
    model_step();
    #1;
    if (gen_on) begin advance(); drive(); end
  endtask

  task automatic cycle();
    pre();
    post();
  endtask

  function automatic bit all_idle();
    bit r;
    r = (m_owner < 0);
    for (int i = 0; i < NREQ; i++) if (rem[i] != 0) r = 0;
    return r;
  endfunction

  task automatic drain(input string name);
    int n;
    n = 0;
    wfull = 1'b0;
    while (!all_idle() && n < 300) begin cycle(); n++; end
    bound_chk(name, n, 300);
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) begin rem[i] = 0; dcnt[i] = 0; end
    gap = '0; wfull = 1'b0;
    drive();
    model_reset();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_winc", winc, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_stall", stall_cnt, 0);
    @(posedge wclk);
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
  endtask

  initial begin
    int n, run, base;
    int runs[$];
    int s0;

    // valid, last, wfull | busy, winc, grant, ready
    tbl[0] = '{4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0};
    tbl[1] = '{4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 2'd0, 4'h1};
    tbl[2] = '{4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0};
    tbl[3] = '{4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 2'd1, 4'h2};
    tbl[4] = '{4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 2'd1, 4'h0};
    tbl[5] = '{4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 2'd2, 4'h4};
    tbl[6] = '{4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 2'd2, 4'h0};
    tbl[7] = '{4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 2'd3, 4'h8};
    tbl[8] = '{4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 2'd3, 4'h0};
    tbl[9] = '{4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 2'd0, 4'h1};

    gen_on = 0; rnd_on = 0;
    do_reset();

    // Reset priority: all requesters with single-beat packets.
    for (int r = 0; r < 10; r++) begin
      req_valid = tbl[r].valid;
      req_last  = tbl[r].last;
      wfull     = tbl[r].wfull;
      pre();
      chk("tbl_busy", busy, tbl[r].busy);
      chk("tbl_winc", winc, tbl[r].winc);
      chk("tbl_grant", grant_id, tbl[r].grant);
      chk("tbl_ready", req_ready, tbl[r].ready);
      post();
    end
    gen_on = 1;
    drive();

    // Packet hold: req1 3-beat packet, req2 waiting.
    log_g.delete(); log_d.delete();
    rem[1] = 3; rem[2] = 1; drive();
    n = 0;
    while (log_g.size() < 4 && n < 20) begin cycle(); n++; end
    bound_chk("hold_wait", n, 20);
    if (log_g.size() >= 4) begin
      for (int k = 0; k < 3; k++) begin
        chk("hold_owner", log_g[k], 1);
        chk("hold_data", log_d[k], 8'h40 + k);
      end
      chk("hold_next_owner", log_g[3], 2);
    end
    drain("hold_drain");

    // Burst cap: req0 10-beat packet while req3 keeps requesting.
    log_g.delete(); log_d.delete();
    base = dcnt[0];
    rem[0] = 10; rem[3] = 1; drive();
    n = 0;
    while (rem[0] > 0 && n < 200) begin
      cycle();
      if (rem[3] == 0 && rem[0] > 0) begin rem[3] = 1; drive(); end
      n++;
    end
    bound_chk("burst_wait", n, 200);
    drain("burst_drain");
    run = 0; n = 0;
    runs.delete();
    foreach (log_g[k]) begin
      if (log_g[k] == 0) begin
        chk("burst_order", log_d[k], (base + n) & 63);
        n++; run++;
      end else if (run > 0) begin
        runs.push_back(run); run = 0;
      end
    end
    if (run > 0) runs.push_back(run);
    chk("burst_total", n, 10);
    chk("burst_runs", runs.size(), 3);
    if (runs.size() == 3) begin
      chk("burst_run0", runs[0], 4);
      chk("burst_run1", runs[1], 4);
      chk("burst_run2", runs[2], 2);
    end

    // Backpressure: wfull held for 5 cycles in the middle of a packet.
    log_g.delete(); log_d.delete();
    base = dcnt[1];
    rem[1] = 6; drive();
    n = 0;
    while (log_g.size() < 2 && n < 20) begin cycle(); n++; end
    bound_chk("bp_wait", n, 20);
    s0 = m_stall;
    wfull = 1'b1;
    repeat (5) begin
      pre();
      chk("bp_winc", winc, 0);
      chk("bp_ready", req_ready, 0);
      post();
    end
    chk("bp_stall", stall_cnt, s0 + 5);
    drain("bp_drain");
    chk("bp_count", log_g.size(), 6);
    foreach (log_g[k]) begin
      chk("bp_owner", log_g[k], 1);
      chk("bp_data", log_d[k], 8'h40 | ((base + k) & 63));
    end

    // Valid drops right after the grant is registered: grant held, no beat.
    rem[2] = 1; drive();
    cycle();
    gap[2] = 1'b1; drive();
    repeat (3) cycle();
    gap = '0; drive();
    drain("gap_drain");

    // Randomized traffic with random backpressure.
    rnd_on = 1;
    for (int c = 0; c < 1500; c++) begin
      wfull = ($urandom_range(2) == 0);
      cycle();
    end
    rnd_on = 0;
    drain("rand_drain");

    // Stall saturation, then asynchronous reset mid-transfer.
    rem[1] = 3; drive();
    cycle();
    wfull = 1'b1;
    repeat (70000) cycle();
    chk("sat_stall", stall_cnt, 16'hFFFF);
    chk("sat_busy", busy, 1);
    #2;
    wrst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_winc", winc, 0);
    chk("arst_ready", req_ready, 0);
    chk("arst_grant", grant_id, 0);
    chk("arst_stall", stall_cnt, 0);
    do_reset();
    rem[2] = 1; rem[3] = 1; drive();
    cycle();
    chk("post_rst_grant", grant_id, 2);
    drain("final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
